// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle shared by the two requesters, the UART tx and the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NB_DATA = 8
) ();
    logic               i_tick;
    logic               i_valid_0;
    logic               i_valid_1;
    logic [NB_DATA-1:0] i_data_0;
    logic [NB_DATA-1:0] i_data_1;
    logic               i_last_0;
    logic               i_last_1;
    logic               i_tx_done;
    logic               o_grant_0;
    logic               o_grant_1;
    logic               o_ack_0;
    logic               o_ack_1;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_timeout;
    logic               o_busy;

    // Arbiter side
    modport slave (
        input  i_tick, i_valid_0, i_valid_1, i_data_0, i_data_1, i_last_0, i_last_1,
        input  i_tx_done,
        output o_grant_0, o_grant_1, o_ack_0, o_ack_1, o_tx_start, o_tx_data,
        output o_timeout, o_busy
    );

    // Requesters / UART tx / baud generator side
    modport master (
        output i_tick, i_valid_0, i_valid_1, i_data_0, i_data_1, i_last_0, i_last_1,
        output i_tx_done,
        input  o_grant_0, o_grant_1, o_ack_0, o_ack_1, o_tx_start, o_tx_data,
        input  o_timeout, o_busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter in front of a single UART transmitter.
// Round-robin per packet, owner keeps the link until its last byte, idle owners are
// evicted after TIMEOUT_CYCLES, and every packet is followed by a GAP_TICKS baud gap.
module uart_tx_arbiter #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned GAP_TICKS      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic             i_clock,
    input logic             i_reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned GapW = $clog2(GAP_TICKS + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StWaitByte,
        StStart,
        StWaitDone,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;   // 0: req0 owns, 1: req1 owns
    logic               ptr_q, ptr_d;       // preferred requester on contention
    logic [NB_DATA-1:0] data_q, data_d;
    logic               last_q, last_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [ToW-1:0]     to_q, to_d;

    logic               ack_0, ack_1, tx_start, timeout;
    logic               own_valid, own_last;
    logic [NB_DATA-1:0] own_data;

    // Inputs of the current owner; the other requester is ignored while owned.
    always_comb begin
        own_valid = owner_q ? bus.i_valid_1 : bus.i_valid_0;
        own_data  = owner_q ? bus.i_data_1  : bus.i_data_0;
        own_last  = owner_q ? bus.i_last_1  : bus.i_last_0;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            gap_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
        end
    end

    // Next-state, counters and one-cycle pulses.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        last_d   = last_q;
        gap_d    = gap_q;
        to_d     = to_q;
        ack_0    = 1'b0;
        ack_1    = 1'b0;
        tx_start = 1'b0;
        timeout  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.i_valid_0 || bus.i_valid_1) begin
                    owner_d = (bus.i_valid_0 && bus.i_valid_1) ? ptr_q : bus.i_valid_1;
                    to_d    = '0;
                    state_d = StWaitByte;
                end
            end
            StWaitByte: begin
                if (own_valid) begin
                    data_d  = own_data;
                    last_d  = own_last;
                    ack_0   = ~owner_q;
                    ack_1   = owner_q;
                    to_d    = '0;
                    state_d = StStart;
                end else if (to_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    ptr_d   = ~owner_q;
                    to_d    = '0;
                    state_d = StIdle;
                end else begin
                    to_d = to_q + ToW'(1);
                end
            end
            StStart: begin
                tx_start = 1'b1;
                state_d  = StWaitDone;
            end
            StWaitDone: begin
                // A tick arriving with done is dropped: the gap starts counting afterwards.
                if (bus.i_tx_done) begin
                    if (last_q) begin
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        to_d    = '0;
                        state_d = StWaitByte;
                    end
                end
            end
            StGap: begin
                if (bus.i_tick) begin
                    if (gap_q == GapW'(GAP_TICKS - 1)) begin
                        gap_d   = '0;
                        ptr_d   = ~owner_q;
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q + GapW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; pulses are masked in the reset cycle so an aborted packet emits nothing.
    always_comb begin
        bus.o_grant_0  = (state_q != StIdle) && !owner_q;
        bus.o_grant_1  = (state_q != StIdle) && owner_q;
        bus.o_ack_0    = ack_0 & ~i_reset;
        bus.o_ack_1    = ack_1 & ~i_reset;
        bus.o_tx_start = tx_start & ~i_reset;
        bus.o_timeout  = timeout & ~i_reset;
        bus.o_tx_data  = data_q;
        bus.o_busy     = (state_q != StIdle);
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester scoreboards filled when bytes
// are presented and drained on every tx_start, plus directed timing checks.
module tb_uart_tx_arbiter;
    localparam int unsigned NbData  = 8;
    localparam int          DoneDly = 50;
    localparam int          TickDiv = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NB_DATA(NbData)) bus ();

    uart_tx_arbiter #(
        .NB_DATA       (NbData),
        .GAP_TICKS     (16),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [7:0]      exp_q0[$];
    logic [7:0]      exp_q1[$];
    int              owner_log[$];
    logic [7:0]      cur_exp;
    bit              in_flight = 0;
    int              n_ack0 = 0, n_ack1 = 0, n_start = 0, n_tmo = 0;
    bit              auto_done = 1, auto_tick = 0, force_done = 0, force_tick = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Baud tick and UART tx model: done pulses DoneDly clocks after each start.
    initial begin : drv_uart
        int  done_timer = 0;
        int  tick_div   = 0;
        bit  pulse;
        bus.i_tick    = 1'b0;
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) done_timer = 0;
            else if (bus.o_tx_start) done_timer = DoneDly;
            @(posedge clk);
            #1;
            tick_div = (tick_div + 1) % TickDiv;
            pulse    = 1'b0;
            if (done_timer > 0) begin
                done_timer--;
                pulse = (done_timer == 0);
            end
            bus.i_tick    = force_tick | (auto_tick & (tick_div == 0));
            bus.i_tx_done = force_done | (auto_done & pulse);
        end
    end

    // Output monitor: scoreboard drain on start, data hold check on done.
    always @(negedge clk) begin
        int owner;
        if (bus.o_ack_0) n_ack0++;
        if (bus.o_ack_1) n_ack1++;
        if (bus.o_timeout) n_tmo++;
        check_eq("grant_not_both", 32'(bus.o_grant_0 & bus.o_grant_1), 32'd0);
        if (rst) in_flight = 0;
        if (bus.o_tx_start) begin
            n_start++;
            check_eq("grant_onehot_at_start", 32'(bus.o_grant_0 ^ bus.o_grant_1), 32'd1);
            owner = bus.o_grant_1 ? 1 : 0;
            owner_log.push_back(owner);
            if ((owner == 1 ? exp_q1.size() : exp_q0.size()) == 0) begin
                check_eq("sb_underflow", 32'(bus.o_tx_data), 32'hFFFF_FFFF);
            end else begin
                cur_exp = (owner == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
                check_eq("tx_data_at_start", 32'(bus.o_tx_data), 32'(cur_exp));
                in_flight = 1;
            end
        end
        if (bus.i_tx_done && in_flight) begin
            check_eq("tx_data_hold", 32'(bus.o_tx_data), 32'(cur_exp));
            in_flight = 0;
        end
    end

    task automatic send_pkt(input bit req, input int n, input logic [7:0] base,
                            input bit last_flag);
        logic [7:0] d;
        bit         lst;
        bit         got;
        for (int i = 0; i < n; i++) begin
            d   = base + 8'(i);
            lst = last_flag && (i == n - 1);
            got = 0;
            if (req) begin
                exp_q1.push_back(d);
                bus.i_valid_1 = 1'b1; bus.i_data_1 = d; bus.i_last_1 = lst;
            end else begin
                exp_q0.push_back(d);
                bus.i_valid_0 = 1'b1; bus.i_data_0 = d; bus.i_last_0 = lst;
            end
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                if (req ? bus.o_ack_1 : bus.o_ack_0) begin
                    got = 1;
                    break;
                end
            end
            check_eq("ack_wait", 32'(got), 32'd1);
            @(posedge clk);
            #1;
            if (req) bus.i_valid_1 = 1'b0;
            else bus.i_valid_0 = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.i_tx_done) begin
                got = 1;
                break;
            end
        end
        check_eq("done_wait", 32'(got), 32'd1);
    endtask

    task automatic wait_start();
        bit got = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.o_tx_start) begin
                got = 1;
                break;
            end
        end
        check_eq("start_wait", 32'(got), 32'd1);
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            force_tick = 1;
            @(posedge clk);
            force_tick = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.i_valid_0 = 1'b0;
        bus.i_valid_1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin : main
        int b, s0, a0, n;
        bus.i_valid_0 = 1'b0; bus.i_valid_1 = 1'b0;
        bus.i_data_0  = '0;   bus.i_data_1  = '0;
        bus.i_last_0  = 1'b0; bus.i_last_1  = 1'b0;

        // Reset state, then spurious done/tick while idle
        do_reset();
        @(negedge clk);
        check_eq("rst_grant0", 32'(bus.o_grant_0), 32'd0);
        check_eq("rst_grant1", 32'(bus.o_grant_1), 32'd0);
        check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
        check_eq("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        check_eq("rst_timeout", 32'(bus.o_timeout), 32'd0);
        s0 = n_start;
        @(posedge clk); force_done = 1; force_tick = 1;
        @(posedge clk); force_done = 0; force_tick = 0;
        repeat (3) @(negedge clk);
        check_eq("idle_spurious_busy", 32'(bus.o_busy), 32'd0);
        check_eq("idle_spurious_start", 32'(n_start - s0), 32'd0);

        // Test 1: three bytes from req0, gap of 16 ticks after last done
        do_reset();
        s0 = n_start; a0 = n_ack0; b = owner_log.size();
        send_pkt(0, 3, 8'hA1, 1);
        wait_done();
        check_eq("t1_acks", 32'(n_ack0 - a0), 32'd3);
        check_eq("t1_starts", 32'(n_start - s0), 32'd3);
        check_eq("t1_owner", 32'(owner_log[b+2]), 32'd0);
        pulse_ticks(15);
        @(negedge clk);
        check_eq("t1_grant_after15", 32'(bus.o_grant_0), 32'd1);
        pulse_ticks(1);
        @(negedge clk);
        check_eq("t1_grant_after16", 32'(bus.o_grant_0), 32'd0);
        check_eq("t1_busy_after16", 32'(bus.o_busy), 32'd0);

        // Test 2: both requesting from reset release, grants alternate 0,1,0
        auto_tick = 1;
        do_reset();
        b = owner_log.size();
        fork
            begin
                send_pkt(0, 1, 8'h10, 1);
                send_pkt(0, 1, 8'h30, 1);
            end
            send_pkt(1, 1, 8'h20, 1);
        join
        repeat (3) @(negedge clk);
        check_eq("t2_nstarts", 32'(owner_log.size() - b), 32'd3);
        if (owner_log.size() - b == 3) begin
            check_eq("t2_owner_first", 32'(owner_log[b]), 32'd0);
            check_eq("t2_owner_second", 32'(owner_log[b+1]), 32'd1);
            check_eq("t2_owner_third", 32'(owner_log[b+2]), 32'd0);
        end

        // Test 3 + spurious events in WAIT_BYTE: req1 idles and is evicted
        auto_tick = 0;
        do_reset();
        send_pkt(1, 1, 8'h3C, 0);
        wait_done();
        n = 0;
        fork
            begin
                for (int c = 0; c < 1200; c++) begin
                    @(negedge clk);
                    n++;
                    if (bus.o_timeout) break;
                end
            end
            begin
                repeat (10) @(posedge clk);
                s0 = n_start;
                force_done = 1; force_tick = 1;
                @(posedge clk);
                force_done = 0; force_tick = 0;
                repeat (3) @(negedge clk);
                check_eq("wb_spurious_start", 32'(n_start - s0), 32'd0);
                check_eq("wb_spurious_grant1", 32'(bus.o_grant_1), 32'd1);
                repeat (100) @(posedge clk);
                #1;
                send_pkt(0, 1, 8'h77, 1);
            end
        join
        check_eq("t3_timeout_cycles", 32'(n), 32'd1024);
        check_eq("t3_tmo_count", 32'(n_tmo), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("t3_grant1_dropped", 32'(bus.o_grant_1), 32'd0);
        check_eq("t3_grant0_next", 32'(bus.o_grant_0), 32'd1);
        check_eq("t3_sb_empty0", 32'(exp_q0.size()), 32'd0);

        // Test 4: reset in WAIT_DONE aborts; late done ignored; req0 wins afterwards
        auto_done = 0;
        auto_tick = 1;
        do_reset();
        send_pkt(1, 1, 8'h99, 1);
        wait_start();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t4_no_start_in_rst", 32'(bus.o_tx_start), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t4_grant0", 32'(bus.o_grant_0), 32'd0);
        check_eq("t4_grant1", 32'(bus.o_grant_1), 32'd0);
        check_eq("t4_acks", 32'({bus.o_ack_0, bus.o_ack_1}), 32'd0);
        check_eq("t4_start", 32'(bus.o_tx_start), 32'd0);
        check_eq("t4_busy", 32'(bus.o_busy), 32'd0);
        check_eq("t4_tx_data", 32'(bus.o_tx_data), 32'd0);
        s0 = n_start;
        @(posedge clk); force_done = 1;
        @(posedge clk); force_done = 0;
        repeat (2) @(negedge clk);
        check_eq("t4_late_done_busy", 32'(bus.o_busy), 32'd0);
        check_eq("t4_late_done_start", 32'(n_start - s0), 32'd0);
        auto_done = 1;
        @(posedge clk);
        #1;
        b = owner_log.size();
        fork
            send_pkt(0, 1, 8'h11, 1);
            send_pkt(1, 1, 8'h22, 1);
        join
        repeat (3) @(negedge clk);
        check_eq("t4_nstarts", 32'(owner_log.size() - b), 32'd2);
        if (owner_log.size() - b == 2) begin
            check_eq("t4_first_owner", 32'(owner_log[b]), 32'd0);
        end

        // Test 6: tick coincident with final done is not counted
        auto_done = 0;
        auto_tick = 0;
        do_reset();
        send_pkt(1, 1, 8'h5C, 1);
        wait_start();
        repeat (3) @(posedge clk);
        force_done = 1; force_tick = 1;
        @(posedge clk);
        force_done = 0; force_tick = 0;
        pulse_ticks(15);
        @(negedge clk);
        check_eq("t6_grant_after15", 32'(bus.o_grant_1), 32'd1);
        pulse_ticks(1);
        @(negedge clk);
        check_eq("t6_grant_after16", 32'(bus.o_grant_1), 32'd0);

        check_eq("sb_final_q0", 32'(exp_q0.size()), 32'd0);
        check_eq("sb_final_q1", 32'(exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
